// File: rtl/nios_blink_led_fader.sv
// LED fader: turns per-LED on/off requests into PWM brightness ramps.
// A shared PWM counter and step prescaler drive N_LED independent duty registers.
module nios_blink_led_fader #(
    parameter int unsigned N_LED      = 4,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 1024,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_LED-1:0] led_in_i,
    input  logic             fade_en_i,
    output logic [N_LED-1:0] led_out_o,
    output logic [N_LED-1:0] busy_o
);

    localparam int unsigned         PreW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MaxDuty = {PWM_BITS{1'b1}};
    localparam logic [PreW-1:0]     PreLast = PreW'(STEP_DIV - 1);

    logic [PWM_BITS-1:0]            pwm_q, pwm_d;
    logic [PreW-1:0]                pre_q, pre_d;
    logic [N_LED-1:0][PWM_BITS-1:0] duty_q, duty_d;
    logic [N_LED-1:0][PWM_BITS-1:0] target;
    logic [N_LED-1:0]               led_on;
    logic [N_LED-1:0]               led_out_q, led_out_d;
    logic                           step_tick;

    assign step_tick = (pre_q == PreLast);

    always_comb begin
        pwm_d = pwm_q + 1'b1;
        pre_d = step_tick ? '0 : pre_q + 1'b1;
        for (int i = 0; i < N_LED; i++) begin
            target[i] = led_in_i[i] ? MaxDuty : '0;
            duty_d[i] = duty_q[i];
            // Target is always 0 or MAX, so stepping toward it saturates naturally.
            if (!fade_en_i) begin
                duty_d[i] = target[i];
            end else if (step_tick) begin
                if (duty_q[i] < target[i]) begin
                    duty_d[i] = duty_q[i] + 1'b1;
                end else if (duty_q[i] > target[i]) begin
                    duty_d[i] = duty_q[i] - 1'b1;
                end
            end
            busy_o[i] = (duty_q[i] != target[i]);
            led_on[i] = (duty_q[i] == MaxDuty) | (duty_q[i] > pwm_q);
        end
        led_out_d = led_on ^ {N_LED{ACTIVE_LOW}};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pwm_q     <= '0;
            pre_q     <= '0;
            duty_q    <= '0;
            led_out_q <= {N_LED{ACTIVE_LOW}};
        end else begin
            pwm_q     <= pwm_d;
            pre_q     <= pre_d;
            duty_q    <= duty_d;
            led_out_q <= led_out_d;
        end
    end

    assign led_out_o = led_out_q;

endmodule

// File: tb/tb_nios_blink_led_fader.sv
// Directed bench for nios_blink_led_fader: main (PWM 4, STEP 4), active-low,
// and slow-step (STEP 64) instances share the same stimulus.
module tb_nios_blink_led_fader;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] led_in;
    logic       fade_en;
    logic [3:0] led_out, busy;
    logic [3:0] al_led_out, al_busy;
    logic [3:0] sl_led_out, sl_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nios_blink_led_fader #(.N_LED(4), .PWM_BITS(4), .STEP_DIV(4), .ACTIVE_LOW(1'b0)) dut (
        .clk_i(clk), .reset_i(reset), .led_in_i(led_in), .fade_en_i(fade_en),
        .led_out_o(led_out), .busy_o(busy)
    );

    nios_blink_led_fader #(.N_LED(4), .PWM_BITS(4), .STEP_DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk_i(clk), .reset_i(reset), .led_in_i(led_in), .fade_en_i(fade_en),
        .led_out_o(al_led_out), .busy_o(al_busy)
    );

    nios_blink_led_fader #(.N_LED(4), .PWM_BITS(4), .STEP_DIV(64), .ACTIVE_LOW(1'b0)) dut_sl (
        .clk_i(clk), .reset_i(reset), .led_in_i(led_in), .fade_en_i(fade_en),
        .led_out_o(sl_led_out), .busy_o(sl_busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for n edges with the given inputs, then release.
    task automatic do_reset(input int n, input logic [3:0] li, input logic fe);
        reset   = 1'b1;
        led_in  = li;
        fade_en = fe;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; led_in = 4'b0000; fade_en = 1'b1;
        tick(3);
        n_cmp++; if (led_out !== 4'b0000) begin n_bad++;
            $display("FAIL reset_led_out got=%b exp=0000", led_out); end
        n_cmp++; if (busy !== 4'b0000) begin n_bad++;
            $display("FAIL reset_busy got=%b exp=0000", busy); end
        n_cmp++; if (dut.duty_q !== 16'h0000) begin n_bad++;
            $display("FAIL reset_duty got=%h exp=0000", dut.duty_q); end
        n_cmp++; if (al_led_out !== 4'b1111) begin n_bad++;
            $display("FAIL reset_al_led_out got=%b exp=1111", al_led_out); end
        reset = 1'b0;
        tick(2);
        n_cmp++; if (dut.step_tick !== 1'b0) begin n_bad++;
            $display("FAIL early_tick got=%b exp=0", dut.step_tick); end
        tick(1);
        n_cmp++; if (dut.step_tick !== 1'b1) begin n_bad++;
            $display("FAIL first_tick got=%b exp=1", dut.step_tick); end
        n_cmp++; if (al_led_out !== 4'b1111) begin n_bad++;
            $display("FAIL idle_al_led_out got=%b exp=1111", al_led_out); end
    endtask

    task automatic test_ramp;
        int unsigned exp;
        int cnt1 = 0;
        int cnt2 = 0;
        do_reset(1, 4'b0001, 1'b1);
        n_cmp++; if (busy !== 4'b0001) begin n_bad++;
            $display("FAIL ramp_busy_reset got=%b exp=0001", busy); end
        for (int e = 1; e <= 200; e++) begin
            tick(1);
            exp = (e / 4 > 15) ? 15 : e / 4;
            n_cmp++; if (dut.duty_q[0] !== 4'(exp)) begin n_bad++;
                $display("FAIL ramp_duty e=%0d got=%0d exp=%0d", e, dut.duty_q[0], exp); end
            n_cmp++; if (busy !== ((exp != 15) ? 4'b0001 : 4'b0000)) begin n_bad++;
                $display("FAIL ramp_busy e=%0d got=%b exp_duty=%0d", e, busy, exp); end
            n_cmp++; if (led_out[3:1] !== 3'b000) begin n_bad++;
                $display("FAIL ramp_idle_ch e=%0d got=%b exp=000", e, led_out[3:1]); end
            if (e >= 61) begin
                n_cmp++; if (led_out[0] !== 1'b1) begin n_bad++;
                    $display("FAIL ramp_full_on e=%0d got=%b exp=1", e, led_out[0]); end
            end
            if (e >= 70 && e <= 85) cnt1 += int'(sl_led_out[0]);
            if (e >= 140 && e <= 155) cnt2 += int'(sl_led_out[0]);
        end
        n_cmp++; if (cnt1 != 1) begin n_bad++;
            $display("FAIL pwm_count_d1 got=%0d exp=1", cnt1); end
        n_cmp++; if (cnt2 != 2) begin n_bad++;
            $display("FAIL pwm_count_d2 got=%0d exp=2", cnt2); end
    endtask

    task automatic test_reversal;
        int exp;
        do_reset(1, 4'b0001, 1'b1);
        tick(32);
        n_cmp++; if (dut.duty_q[0] !== 4'd8) begin n_bad++;
            $display("FAIL rev_start got=%0d exp=8", dut.duty_q[0]); end
        led_in = 4'b0000;
        for (int e = 33; e <= 70; e++) begin
            tick(1);
            exp = (e < 36) ? 8 : 8 - (e - 32) / 4;
            if (exp < 0) exp = 0;
            n_cmp++; if (dut.duty_q[0] !== 4'(exp)) begin n_bad++;
                $display("FAIL rev_duty e=%0d got=%0d exp=%0d", e, dut.duty_q[0], exp); end
            n_cmp++; if (busy !== ((exp != 0) ? 4'b0001 : 4'b0000)) begin n_bad++;
                $display("FAIL rev_busy e=%0d got=%b exp_duty=%0d", e, busy, exp); end
        end
    endtask

    task automatic test_no_fade;
        do_reset(1, 4'b0000, 1'b0);
        tick(2);
        led_in = 4'b1111;
        tick(1);
        n_cmp++; if (dut.duty_q !== 16'hffff) begin n_bad++;
            $display("FAIL nofade_duty got=%h exp=ffff", dut.duty_q); end
        n_cmp++; if (busy !== 4'b0000) begin n_bad++;
            $display("FAIL nofade_busy got=%b exp=0000", busy); end
        n_cmp++; if (led_out !== 4'b0000) begin n_bad++;
            $display("FAIL nofade_lag got=%b exp=0000", led_out); end
        tick(1);
        n_cmp++; if (led_out !== 4'b1111) begin n_bad++;
            $display("FAIL nofade_on got=%b exp=1111", led_out); end
        n_cmp++; if (al_led_out !== 4'b0000) begin n_bad++;
            $display("FAIL nofade_al_on got=%b exp=0000", al_led_out); end
        led_in = 4'b0000;
        tick(1);
        n_cmp++; if (led_out !== 4'b1111) begin n_bad++;
            $display("FAIL nofade_off_lag got=%b exp=1111", led_out); end
        tick(1);
        n_cmp++; if (led_out !== 4'b0000) begin n_bad++;
            $display("FAIL nofade_off got=%b exp=0000", led_out); end
    endtask

    task automatic test_fade_toggle;
        do_reset(1, 4'b0001, 1'b1);
        tick(8);
        n_cmp++; if (dut.duty_q[0] !== 4'd2) begin n_bad++;
            $display("FAIL tog_pre got=%0d exp=2", dut.duty_q[0]); end
        fade_en = 1'b0;
        tick(1);
        n_cmp++; if (dut.duty_q[0] !== 4'd15) begin n_bad++;
            $display("FAIL tog_jump got=%0d exp=15", dut.duty_q[0]); end
        fade_en = 1'b1;
        led_in  = 4'b0000;
        tick(2);
        n_cmp++; if (dut.duty_q[0] !== 4'd15) begin n_bad++;
            $display("FAIL tog_hold got=%0d exp=15", dut.duty_q[0]); end
        tick(1);
        n_cmp++; if (dut.duty_q[0] !== 4'd14) begin n_bad++;
            $display("FAIL tog_resume got=%0d exp=14", dut.duty_q[0]); end
    endtask

    task automatic test_reset_midramp;
        do_reset(1, 4'b0100, 1'b1);
        tick(41);
        n_cmp++; if (dut.duty_q[2] !== 4'd10) begin n_bad++;
            $display("FAIL mid_duty got=%0d exp=10", dut.duty_q[2]); end
        reset = 1'b1;
        tick(1);
        n_cmp++; if (dut.duty_q !== 16'h0000) begin n_bad++;
            $display("FAIL mid_reset_duty got=%h exp=0000", dut.duty_q); end
        n_cmp++; if (dut.pwm_q !== 4'd0 || dut.pre_q !== 2'd0) begin n_bad++;
            $display("FAIL mid_reset_cnt got pwm=%0d pre=%0d exp=0/0", dut.pwm_q, dut.pre_q); end
        n_cmp++; if (led_out[2] !== 1'b0) begin n_bad++;
            $display("FAIL mid_reset_led got=%b exp=0", led_out[2]); end
        reset = 1'b0;
        tick(3);
        n_cmp++; if (dut.duty_q[2] !== 4'd0) begin n_bad++;
            $display("FAIL mid_restart0 got=%0d exp=0", dut.duty_q[2]); end
        tick(1);
        n_cmp++; if (dut.duty_q[2] !== 4'd1) begin n_bad++;
            $display("FAIL mid_restart1 got=%0d exp=1", dut.duty_q[2]); end
    endtask

    initial begin
        reset = 1'b1; led_in = 4'b0000; fade_en = 1'b1;
        test_reset();
        test_ramp();
        test_reversal();
        test_no_fade();
        test_fade_toggle();
        test_reset_midramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
